// File: rtl/lcd_bus_strobe_if.sv
// Request handshake plus HD44780-style pin bundle between the LCD sequencer,
// the strobe stage and the panel.
interface lcd_bus_strobe_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_RS;
  logic [7:0] REQ_DATA;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;
  logic       BUSY;
  logic       DONE;

  modport master (
    output REQ_VALID, REQ_RS, REQ_DATA,
    input  REQ_READY, LCD_E, LCD_RS, LCD_RW, LCD_DATA, BUSY, DONE
  );

  modport slave (
    input  REQ_VALID, REQ_RS, REQ_DATA,
    output REQ_READY, LCD_E, LCD_RS, LCD_RW, LCD_DATA, BUSY, DONE
  );
endinterface

// File: rtl/lcd_bus_strobe.sv
// Timed HD44780 write strobe: setup, E pulse, hold, then an execution wait
// (long for clear/home) before the next byte is accepted.
module lcd_bus_strobe #(
  parameter int T_SETUP     = 2,
  parameter int T_PW        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 40,
  parameter int T_EXEC_LONG = 1640,
  parameter int CW          = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  lcd_bus_strobe_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4
  } state_t;

  // Timer reload values: each phase lasts exactly T_x cycles.
  localparam logic [CW-1:0] LD_SETUP     = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_PW        = CW'(T_PW - 1);
  localparam logic [CW-1:0] LD_HOLD      = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_EXEC      = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LD_EXEC_LONG = CW'(T_EXEC_LONG - 1);

  state_t          state_reg;
  logic [CW-1:0]   timer_reg;
  logic            long_reg;
  logic            e_reg;
  logic            rs_reg;
  logic [7:0]      data_reg;
  logic            done_reg;

  logic            ready;
  logic            accept;
  logic            long_req;
  logic            timer_zero;

  assign ready      = (state_reg == S_IDLE) & RESETN;
  assign accept     = bus.REQ_VALID & ready;
  assign timer_zero = (timer_reg == '0);
  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign long_req   = ~bus.REQ_RS & (bus.REQ_DATA[7:2] == 6'd0) & (bus.REQ_DATA[1:0] != 2'd0);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_reg <= S_IDLE;
      timer_reg <= '0;
      long_reg  <= 1'b0;
      e_reg     <= 1'b0;
      rs_reg    <= 1'b0;
      data_reg  <= 8'h00;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          e_reg <= 1'b0;
          if (accept) begin
            state_reg <= S_SETUP;
            timer_reg <= LD_SETUP;
            rs_reg    <= bus.REQ_RS;
            data_reg  <= bus.REQ_DATA;
            long_reg  <= long_req;
          end
        end
        S_SETUP: begin
          if (timer_zero) begin
            state_reg <= S_PULSE;
            timer_reg <= LD_PW;
            e_reg     <= 1'b1;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        S_PULSE: begin
          if (timer_zero) begin
            state_reg <= S_HOLD;
            timer_reg <= LD_HOLD;
            e_reg     <= 1'b0;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        S_HOLD: begin
          if (timer_zero) begin
            state_reg <= S_EXEC;
            timer_reg <= long_reg ? LD_EXEC_LONG : LD_EXEC;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        S_EXEC: begin
          if (timer_zero) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b1;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          timer_reg <= '0;
          e_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.REQ_READY = ready;
  assign bus.BUSY      = ~ready;
  assign bus.LCD_E     = e_reg;
  assign bus.LCD_RS    = rs_reg;
  assign bus.LCD_RW    = 1'b0;
  assign bus.LCD_DATA  = data_reg;
  assign bus.DONE      = done_reg;

endmodule

// File: tb/tb_lcd_bus_strobe.sv
// Directed stimulus with a queue-based scoreboard; a negedge monitor checks every
// pin against the expected transfer timeline of the queue head.
module tb_lcd_bus_strobe;

  logic CLK;
  logic RESETN;

  lcd_bus_strobe_if bus ();

  lcd_bus_strobe dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  typedef struct {
    int         acc;
    logic       rs;
    logic [7:0] data;
    int         done;
  } exp_t;

  exp_t q[$];

  int   cyc = 0;
  bit   started = 0;
  bit   rst_at_edge = 0;
  int   errors = 0;
  int   checks = 0;
  logic       last_rs = 1'b0;
  logic [7:0] last_data = 8'h00;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !RESETN;
    started     <= 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: expected pin values derived from the scoreboard head and cycle count.
  always @(negedge CLK) begin
    if (started) begin
      chk("rw", {31'd0, bus.LCD_RW}, 32'd0);
      if (rst_at_edge) begin
        q.delete();
        last_rs   = 1'b0;
        last_data = 8'h00;
        chk("rst_e",     {31'd0, bus.LCD_E},    32'd0);
        chk("rst_rs",    {31'd0, bus.LCD_RS},   32'd0);
        chk("rst_data",  {24'd0, bus.LCD_DATA}, 32'd0);
        chk("rst_done",  {31'd0, bus.DONE},     32'd0);
        chk("rst_ready", {31'd0, bus.REQ_READY}, {31'd0, RESETN});
      end else begin
        bit         in_xfer;
        bit         exp_e;
        bit         exp_done;
        bit         exp_ready;
        logic       exp_rs;
        logic [7:0] exp_data;
        in_xfer = (q.size() > 0) && (cyc >= q[0].acc);
        if (in_xfer) begin
          exp_e     = (cyc >= q[0].acc + 2) && (cyc <= q[0].acc + 13);
          exp_done  = (cyc == q[0].done);
          exp_ready = exp_done;
          exp_rs    = q[0].rs;
          exp_data  = q[0].data;
        end else begin
          exp_e     = 1'b0;
          exp_done  = 1'b0;
          exp_ready = 1'b1;
          exp_rs    = last_rs;
          exp_data  = last_data;
        end
        chk("lcd_e",  {31'd0, bus.LCD_E},     {31'd0, exp_e});
        chk("done",   {31'd0, bus.DONE},      {31'd0, exp_done});
        chk("ready",  {31'd0, bus.REQ_READY}, {31'd0, exp_ready});
        chk("busy",   {31'd0, bus.BUSY},      {31'd0, !exp_ready});
        chk("lcd_rs", {31'd0, bus.LCD_RS},    {31'd0, exp_rs});
        chk("lcd_data", {24'd0, bus.LCD_DATA}, {24'd0, exp_data});
        if (in_xfer && exp_done) begin
          $display("xfer rs=%0d data=%02h accept=%0d done=%0d", q[0].rs, q[0].data, q[0].acc, q[0].done);
          last_rs   = q[0].rs;
          last_data = q[0].data;
          void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [7:0] pat(input int c);
    return 8'(c * 37 + 5);
  endfunction

  task automatic send(input logic rs, input logic [7:0] d, input bit lng, output int acc);
    int n;
    n   = 0;
    acc = -1;
    while (!bus.REQ_READY && n < 4000) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (!bus.REQ_READY) begin
      errors++;
      $display("FAIL send_timeout cyc=%0d got=ready_low expected=ready_high", cyc);
      return;
    end
    bus.REQ_VALID = 1'b1;
    bus.REQ_RS    = rs;
    bus.REQ_DATA  = d;
    acc = cyc + 1;
    q.push_back('{acc, rs, d, acc + (lng ? 1656 : 56)});
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_RS    = ~rs;
    bus.REQ_DATA  = ~d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() > 0 && n < 4000) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout cyc=%0d got=%0d pending expected=0 pending", cyc, q.size());
      q.delete();
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    bit         lng;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int a;
    int a0;
    vecs[0] = '{1'b1, 8'h44, 1'b0};
    vecs[1] = '{1'b0, 8'h01, 1'b1};
    vecs[2] = '{1'b0, 8'h02, 1'b1};
    vecs[3] = '{1'b0, 8'h03, 1'b1};
    vecs[4] = '{1'b1, 8'h01, 1'b0};
    vecs[5] = '{1'b0, 8'h06, 1'b0};

    RESETN        = 1'b0;
    bus.REQ_VALID = 1'b0;
    bus.REQ_RS    = 1'b0;
    bus.REQ_DATA  = 8'h00;

    repeat (3) @(posedge CLK);
    #1;
    RESETN = 1'b1;
    @(posedge CLK); #1;

    // Single transfers: short, clear/home long, short lookalikes.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].rs, vecs[i].data, vecs[i].lng, a);
      wait_idle();
    end

    // Valid held high with data changing every cycle: accepts every 57 cycles.
    a0 = cyc + 1;
    bus.REQ_VALID = 1'b1;
    bus.REQ_RS    = 1'b1;
    for (int k = 0; k < 3; k++)
      q.push_back('{a0 + 57 * k, 1'b1, pat(a0 + 57 * k), a0 + 57 * k + 56});
    bus.REQ_DATA = pat(cyc + 1);
    while (cyc < a0 + 114) begin
      @(posedge CLK); #1;
      bus.REQ_DATA = pat(cyc + 1);
    end
    bus.REQ_VALID = 1'b0;
    wait_idle();

    // Reset sampled at spec cycle 8 (mid-pulse), then a fresh transfer.
    send(1'b1, 8'hA5, 1'b0, a);
    while (cyc < a + 7) begin
      @(posedge CLK); #1;
    end
    RESETN = 1'b0;
    @(posedge CLK); #1;
    RESETN = 1'b1;
    @(posedge CLK); #1;
    send(1'b0, 8'h06, 1'b0, a);
    wait_idle();

    repeat (3) @(posedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
